// File: rtl/nona_pkg.sv
// Shared opcode constants and the instruction word layout used by the
// dispatch arbiter and by the execute block bench.
package nona_pkg;

    localparam logic [7:0] OP_NOP = 8'h15;
    localparam logic [7:0] OP_HLT = 8'h14;

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] op1;
        logic [7:0] op2;
    } instr_word_t;

endpackage

// File: rtl/core_dispatch_arbiter_fifo.sv
// Per-core instruction word FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate level counter.
module dispatch_fifo
    import nona_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  instr_word_t din,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output instr_word_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    instr_word_t mem_q [DEPTH];
    instr_word_t mem_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointer values and storage write for this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            mem_d[wr_ptr_q[AW-1:0]] = din;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointers are control state and are cleared by reset, discarding contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is only meaningful between the pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/core_dispatch_arbiter.sv
// Issue stage for the execute block: per-core FIFOs, round-robin selection
// of one eligible core per cycle, a registered issue slot, and halt tracking.
module core_dispatch_arbiter
    import nona_pkg::*;
#(
    parameter int NUM_CORES  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CORE_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [CORE_W-1:0]    in_core,
    input  logic [7:0]           in_instr,
    input  logic [7:0]           in_op1,
    input  logic [7:0]           in_op2,
    output logic                 in_ready,
    input  logic [NUM_CORES-1:0] resume,
    input  logic                 exec_ready,
    output logic                 out_valid,
    output logic [CORE_W-1:0]    out_core_id,
    output logic [7:0]           out_instr,
    output logic [7:0]           out_op1,
    output logic [7:0]           out_op2,
    output logic [NUM_CORES-1:0] halted,
    output logic [NUM_CORES-1:0] fifo_empty
);

    instr_word_t           in_word;
    instr_word_t           head [NUM_CORES];
    logic [NUM_CORES-1:0]  push;
    logic [NUM_CORES-1:0]  pop;
    logic [NUM_CORES-1:0]  full;
    logic [NUM_CORES-1:0]  eligible;
    logic [NUM_CORES-1:0]  gnt_oh;
    logic                  found;
    logic                  update;
    logic [CORE_W-1:0]     grant;
    instr_word_t           grant_word;

    logic                  out_valid_q, out_valid_d;
    logic [CORE_W-1:0]     out_core_id_q, out_core_id_d;
    instr_word_t           out_word_q, out_word_d;
    logic [NUM_CORES-1:0]  halted_q, halted_d;
    logic [CORE_W-1:0]     last_q, last_d;

    assign in_word     = {in_instr, in_op1, in_op2};
    assign eligible    = ~fifo_empty & ~halted_q;
    assign update      = exec_ready || !out_valid_q;
    assign out_valid   = out_valid_q;
    assign out_core_id = out_core_id_q;
    assign out_instr   = out_word_q.instr;
    assign out_op1     = out_word_q.op1;
    assign out_op2     = out_word_q.op2;
    assign halted      = halted_q;

    // Push decode: readiness depends only on the registered full flags, so a
    // same-cycle pop never makes room for a push. Out-of-range cores match nothing.
    always_comb begin
        in_ready = 1'b0;
        push     = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (in_core == CORE_W'(c) && !full[c]) begin
                in_ready = 1'b1;
                push[c]  = in_valid;
            end
        end
    end

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_fifo
        dispatch_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[c]),
            .din   (in_word),
            .pop   (pop[c]),
            .full  (full[c]),
            .empty (fifo_empty[c]),
            .head  (head[c])
        );
    end

    // Round-robin search starting just after the last granted core.
    always_comb begin
        found      = 1'b0;
        grant      = '0;
        gnt_oh     = '0;
        grant_word = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                if (!found && eligible[c] && ((int'(last_q) + i) % NUM_CORES) == c) begin
                    found      = 1'b1;
                    grant      = CORE_W'(c);
                    gnt_oh[c]  = 1'b1;
                    grant_word = head[c];
                end
            end
        end
    end

    // Issue slot, round-robin pointer and halt flags; a loaded HLT beats a resume.
    always_comb begin
        pop           = '0;
        out_valid_d   = out_valid_q;
        out_core_id_d = out_core_id_q;
        out_word_d    = out_word_q;
        last_d        = last_q;
        halted_d      = halted_q & ~resume;
        if (update) begin
            if (found) begin
                pop           = gnt_oh;
                out_valid_d   = 1'b1;
                out_core_id_d = grant;
                out_word_d    = grant_word;
                last_d        = grant;
                if (grant_word.instr == OP_HLT) begin
                    halted_d = halted_d | gnt_oh;
                end
            end else begin
                out_valid_d   = 1'b0;
                out_core_id_d = '0;
                out_word_d    = {OP_NOP, 16'h0000};
            end
        end
    end

    // Registered issue state; reset leaves a NOP in the slot and core 0 first in line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_core_id_q <= '0;
            out_word_q    <= {OP_NOP, 16'h0000};
            halted_q      <= '0;
            last_q        <= CORE_W'(NUM_CORES - 1);
        end else begin
            out_valid_q   <= out_valid_d;
            out_core_id_q <= out_core_id_d;
            out_word_q    <= out_word_d;
            halted_q      <= halted_d;
            last_q        <= last_d;
        end
    end

endmodule

// File: tb/tb_core_dispatch_arbiter.sv
// Bench for core_dispatch_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_core_dispatch_arbiter;
    import nona_pkg::*;

    localparam int NC    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [CW-1:0] in_core;
    logic [7:0]    in_instr, in_op1, in_op2;
    logic          in_ready;
    logic [NC-1:0] resume;
    logic          exec_ready;
    logic          out_valid;
    logic [CW-1:0] out_core_id;
    logic [7:0]    out_instr, out_op1, out_op2;
    logic [NC-1:0] halted;
    logic [NC-1:0] fifo_empty;

    always #5 clk = ~clk;

    core_dispatch_arbiter #(
        .NUM_CORES  (NC),
        .FIFO_DEPTH (DEPTH),
        .CORE_W     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_core     (in_core),
        .in_instr    (in_instr),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .in_ready    (in_ready),
        .resume      (resume),
        .exec_ready  (exec_ready),
        .out_valid   (out_valid),
        .out_core_id (out_core_id),
        .out_instr   (out_instr),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .halted      (halted),
        .fifo_empty  (fifo_empty)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: one queue per core plus the architectural slot state.
    logic [23:0]   mq [NC][$];
    logic [NC-1:0] m_halt;
    int            m_last;
    logic          m_valid;
    int            m_core;
    logic [23:0]   m_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) mq[c].delete();
        m_halt  = '0;
        m_last  = NC - 1;
        m_valid = 1'b0;
        m_core  = 0;
        m_word  = {OP_NOP, 16'h0000};
    endtask

    // One clock edge of the model, from the inputs held before that edge.
    task automatic model_edge(input logic v, input int c, input logic [23:0] w,
                              input logic [NC-1:0] res, input logic er);
        bit            push_ok;
        bit            found;
        int            g;
        logic [NC-1:0] h_next;
        push_ok = 1'b0;
        if (v && c < NC) push_ok = (mq[c].size() < DEPTH);
        h_next = m_halt & ~res;
        if (er || !m_valid) begin
            found = 1'b0;
            g     = 0;
            for (int i = 1; i <= NC; i++) begin
                int k;
                k = (m_last + i) % NC;
                if (!found && mq[k].size() > 0 && !m_halt[k]) begin
                    found = 1'b1;
                    g     = k;
                end
            end
            if (found) begin
                m_word  = mq[g].pop_front();
                m_valid = 1'b1;
                m_core  = g;
                m_last  = g;
                if (m_word[23:16] == OP_HLT) h_next[g] = 1'b1;
            end else begin
                m_word  = {OP_NOP, 16'h0000};
                m_valid = 1'b0;
                m_core  = 0;
            end
        end
        if (push_ok) mq[c].push_back(w);
        m_halt = h_next;
    endtask

    task automatic check_outputs();
        logic [NC-1:0] exp_empty;
        for (int c = 0; c < NC; c++) exp_empty[c] = (mq[c].size() == 0);
        check("out_valid",   32'(out_valid),   32'(m_valid));
        check("out_core_id", 32'(out_core_id), 32'(m_core));
        check("out_instr",   32'(out_instr),   32'(m_word[23:16]));
        check("out_op1",     32'(out_op1),     32'(m_word[15:8]));
        check("out_op2",     32'(out_op2),     32'(m_word[7:0]));
        check("halted",      32'(halted),      32'(m_halt));
        check("fifo_empty",  32'(fifo_empty),  32'(exp_empty));
    endtask

    // Drive one cycle of inputs (called just after a falling edge).
    task automatic cyc(input logic v, input int c, input logic [7:0] ins,
                       input logic [7:0] o1, input logic [7:0] o2,
                       input logic [NC-1:0] res, input logic er);
        logic exp_rdy;
        in_valid   = v;
        in_core    = CW'(c);
        in_instr   = ins;
        in_op1     = o1;
        in_op2     = o2;
        resume     = res;
        exec_ready = er;
        #1;
        exp_rdy = 1'b0;
        if (c < NC) exp_rdy = (mq[c].size() < DEPTH);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        model_edge(v, c, {ins, o1, o2}, res, er);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle(input logic er);
        cyc(1'b0, 0, 8'h00, 8'h00, 8'h00, '0, er);
    endtask

    // Assert reset in the middle of a cycle, hold it over one edge, release.
    task automatic mid_reset();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    int rr_exp [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        int            n5;
        logic [7:0]    held_op1;
        logic          v;
        int            c;
        logic [7:0]    ins;
        logic [NC-1:0] res;
        logic          er;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_core    = '0;
        in_instr   = 8'h00;
        in_op1     = 8'h00;
        in_op2     = 8'h00;
        resume     = '0;
        exec_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check("reset_instr_nop", 32'(out_instr), 32'h15);
        check("reset_empty", 32'(fifo_empty), 32'hFF);
        @(negedge clk);
        reset = 1'b0;

        // Single core: word appears one edge after its push, then NOP.
        cyc(1'b1, 2, 8'h00, 8'h01, 8'h55, '0, 1'b1);
        check("single_not_yet", 32'(out_valid), 32'h0);
        idle(1'b1);
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_core", 32'(out_core_id), 32'h2);
        check("single_word", {8'h00, out_instr, out_op1, out_op2}, 32'h0000_0155);
        idle(1'b1);
        check("single_nop", {23'h0, out_valid, out_instr}, 32'h15);

        // Round-robin: park core 7 in the slot while cores 0,1,3 fill.
        cyc(1'b1, 7, 8'h01, 8'h70, 8'h00, '0, 1'b0);
        cyc(1'b1, 0, 8'h02, 8'h00, 8'h00, '0, 1'b0);
        cyc(1'b1, 0, 8'h02, 8'h01, 8'h00, '0, 1'b0);
        cyc(1'b1, 1, 8'h02, 8'h10, 8'h00, '0, 1'b0);
        cyc(1'b1, 1, 8'h02, 8'h11, 8'h00, '0, 1'b0);
        cyc(1'b1, 3, 8'h02, 8'h30, 8'h00, '0, 1'b0);
        cyc(1'b1, 3, 8'h02, 8'h31, 8'h00, '0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            check("rr_order", 32'(out_core_id), 32'(rr_exp[k]));
        end
        idle(1'b1);
        check("rr_then_nop", 32'(out_valid), 32'h0);

        // Backpressure: fill core 5 behind a held slot.
        cyc(1'b1, 7, 8'h01, 8'h71, 8'h00, '0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 5, 8'h03, 8'(8'h50 + k), 8'h00, '0, 1'b0);
        cyc(1'b1, 5, 8'h03, 8'h5F, 8'h00, '0, 1'b0);
        check("full_core5", 32'(in_ready), 32'h0);
        cyc(1'b1, 6, 8'h04, 8'h60, 8'h00, '0, 1'b0);
        check("ready_core6", 32'(in_ready), 32'h1);
        held_op1 = out_op1;
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            check("hold_core", 32'(out_core_id), 32'h7);
            check("hold_op1", 32'(out_op1), 32'(held_op1));
        end
        n5 = 0;
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            if (out_valid && out_core_id == 4'd5) begin
                check("core5_order", 32'(out_op1), 32'(8'h50 + n5));
                n5++;
            end
        end
        check("core5_count", 32'(n5), 32'h4);

        // Halt: MOV behind HLT is withheld until resume.
        cyc(1'b1, 1, OP_HLT, 8'hA0, 8'h00, '0, 1'b1);
        cyc(1'b1, 1, 8'h01, 8'hA1, 8'h00, '0, 1'b1);
        check("hlt_issued", 32'(out_instr), 32'h14);
        idle(1'b1);
        check("halted1", 32'(halted[1]), 32'h1);
        check("mov_withheld", 32'(out_valid), 32'h0);
        cyc(1'b0, 0, 8'h00, 8'h00, 8'h00, NC'(2), 1'b1);
        idle(1'b1);
        check("mov_after_resume", {out_core_id, out_instr, out_op1}, {4'h1, 8'h01, 8'hA1});

        // Resume on the same edge as an HLT load: the set wins.
        cyc(1'b1, 1, OP_HLT, 8'hB0, 8'h00, '0, 1'b1);
        cyc(1'b0, 0, 8'h00, 8'h00, 8'h00, NC'(2), 1'b1);
        check("collide_halted", 32'(halted[1]), 32'h1);
        cyc(1'b0, 0, 8'h00, 8'h00, 8'h00, NC'(2), 1'b1);
        check("collide_resumed", 32'(halted[1]), 32'h0);

        // Out-of-range core is refused and writes nothing.
        cyc(1'b1, 9, 8'h05, 8'h99, 8'h99, '0, 1'b1);
        check("oor_ready", 32'(in_ready), 32'h0);
        check("oor_empty", 32'(fifo_empty), 32'hFF);

        // Reset mid-traffic with words queued in several cores.
        cyc(1'b1, 4, 8'h01, 8'h40, 8'h00, '0, 1'b0);
        cyc(1'b1, 2, 8'h01, 8'h20, 8'h00, '0, 1'b0);
        cyc(1'b1, 2, 8'h01, 8'h21, 8'h00, '0, 1'b0);
        cyc(1'b1, 6, 8'h01, 8'h61, 8'h00, '0, 1'b0);
        mid_reset();
        for (int k = 0; k < 4; k++) idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) mid_reset();
            v   = ($urandom_range(0, 3) != 0);
            c   = int'($urandom_range(0, 9));
            ins = ($urandom_range(0, 7) == 0) ? OP_HLT : 8'($urandom);
            res = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
            er  = ($urandom_range(0, 3) != 0);
            cyc(v, c, ins, 8'($urandom), 8'($urandom), res, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
